// File: rtl/ins_loader_pkg.sv
// ins_loader_pkg : shared state encoding and big-endian byte lane selection
// rev 1.0
`default_nettype none

package ins_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WRITE  = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    localparam int BYTES_PER_WORD = 4;

    // Index 0 is the most significant byte; it lands at the lowest address.
    function automatic logic [7:0] byte_select(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ins_loader.sv
// ins_loader : streams 32-bit words into a byte-wide instruction store, MSB first
// rev 1.0
`default_nettype none

module ins_loader
    import ins_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MEM_BYTES = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              in_valid_i,
    input  logic [31:0]       in_data_i,
    input  logic              in_last_i,
    output logic              in_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              overflow_o,
    output logic [ADDR_W-2:0] word_count_o
);

    // One extra bit so the pointer can sit at MEM_BYTES without wrapping.
    localparam logic [ADDR_W:0] C_BASE  = (ADDR_W+1)'(BASE_ADDR);
    localparam logic [ADDR_W:0] C_LIMIT = (ADDR_W+1)'(MEM_BYTES);
    localparam logic [ADDR_W:0] C_STEP  = (ADDR_W+1)'(BYTES_PER_WORD);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   ptr_q, ptr_d;
    logic [31:0]       word_q, word_d;
    logic              last_q, last_d;
    logic [1:0]        idx_q, idx_d;
    logic [ADDR_W-2:0] count_q, count_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [1:0]        idx_nxt;
    logic              room;

    assign idx_nxt = idx_q + 2'd1;
    assign room    = (ptr_q < C_LIMIT);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        word_d     = word_q;
        last_d     = last_q;
        idx_d      = idx_q;
        count_d    = count_q;
        done_d     = done_q;
        ovf_d      = ovf_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        in_ready_o = 1'b0;

        case (state_q)
            ST_IDLE, ST_FINISH: begin
                if (start_i) begin
                    ptr_d   = C_BASE;
                    count_d = '0;
                    done_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                if (!room) begin
                    ovf_d   = 1'b1;
                    state_d = ST_FINISH;
                end else begin
                    in_ready_o = 1'b1;
                    if (in_valid_i) begin
                        // Byte 0 is registered on the handshake edge so the
                        // first strobe appears the very next cycle.
                        word_d  = in_data_i;
                        last_d  = in_last_i;
                        idx_d   = 2'd0;
                        we_d    = 1'b1;
                        addr_d  = ptr_q[ADDR_W-1:0];
                        wdata_d = byte_select(in_data_i, 2'd0);
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (idx_q == 2'd3) begin
                    ptr_d   = ptr_q + C_STEP;
                    count_d = count_q + (ADDR_W-1)'(1);
                    if (last_q) begin
                        done_d  = 1'b1;
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_ACCEPT;
                    end
                end else begin
                    idx_d   = idx_nxt;
                    we_d    = 1'b1;
                    addr_d  = ptr_q[ADDR_W-1:0] + ADDR_W'(idx_nxt);
                    wdata_d = byte_select(word_q, idx_nxt);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= C_BASE;
            word_q  <= '0;
            last_q  <= 1'b0;
            idx_q   <= 2'd0;
            count_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            word_q  <= word_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_we_o     = we_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign busy_o       = (state_q == ST_ACCEPT) || (state_q == ST_WRITE);
    assign done_o       = done_q;
    assign overflow_o   = ovf_q;
    assign word_count_o = count_q;

endmodule

`default_nettype wire
